// File: rtl/ring_arb_pkg.sv
// Shared types and default sizing for the ring arbiter slice.
// Default constants are used as parameter defaults by ring_arbiter and ring_ptr.
package ring_arb_pkg;

    localparam int N_DEFAULT        = 4;
    localparam int HOLD_MAX_DEFAULT = 15;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ring_ptr.sv
// One-hot round-robin search pointer.
// On load it moves to the position just after the one-hot pos input, wrapping N-1 -> 0.
module ring_ptr
    import ring_arb_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] pos,
    output logic [N-1:0] ptr
);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= N'(1);
        end else if (load) begin
            ptr <= {pos[N-2:0], pos[N-1]};
        end
    end

endmodule

// File: rtl/ring_arbiter.sv
// Round-robin arbiter: one registered one-hot grant, held until release, request drop,
// or HOLD_MAX cycles; the ring pointer then advances past the winner.
module ring_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N        = N_DEFAULT,
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         rel,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id,
    output logic [N-1:0]         ptr,
    output logic                 timeout
);

    localparam int IW = $clog2(N);
    localparam int SW = IW + 1;
    localparam int CW = $clog2(HOLD_MAX + 1);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic [N-1:0]  grant_d;
    logic [IW-1:0] gid_d;
    logic [CW-1:0] hold_q;
    logic [CW-1:0] hold_d;
    logic          timeout_d;
    logic          armed_q;
    logic          ptr_load;

    logic [IW-1:0] start_id;
    logic [SW-1:0] scan_sum;
    logic [IW-1:0] scan_id;
    logic [N-1:0]  pick;
    logic [IW-1:0] pick_id;
    logic          found;
    logic          exit_done;

    ring_ptr #(.N(N)) u_ring_ptr (
        .clk   (clk),
        .reset (reset),
        .load  (ptr_load),
        .pos   (grant),
        .ptr   (ptr)
    );

    always_comb begin
        start_id = '0;
        for (int i = 0; i < N; i++) begin
            if (ptr[i]) start_id = IW'(i);
        end
    end

    // Priority search starting at the pointer position, wrapping modulo N.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        pick     = '0;
        pick_id  = '0;
        found    = 1'b0;
        scan_sum = '0;
        scan_id  = '0;
        for (int k = 0; k < N; k++) begin
            scan_sum = {1'b0, start_id} + SW'(k);
            if (scan_sum >= SW'(N)) scan_sum = scan_sum - SW'(N);
            scan_id = scan_sum[IW-1:0];
            if (!found && req[scan_id]) begin
                found         = 1'b1;
                pick[scan_id] = 1'b1;
                pick_id       = scan_id;
            end
        end
    end

    assign exit_done = rel[grant_id] || !req[grant_id];

    always_comb begin
        state_d   = state_q;
        grant_d   = grant;
        gid_d     = grant_id;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        ptr_load  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // armed_q holds off the first grant until one full edge after reset release.
                if (armed_q && found) begin
                    state_d = GRANT;
                    grant_d = pick;
                    gid_d   = pick_id;
                    hold_d  = CW'(1);
                end
            end
            GRANT: begin
                if (exit_done || hold_q == CW'(HOLD_MAX)) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    hold_d    = '0;
                    ptr_load  = 1'b1;
                    timeout_d = !exit_done;
                end else begin
                    hold_d = hold_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            hold_q      <= '0;
            timeout     <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant       <= grant_d;
            grant_valid <= |grant_d;
            grant_id    <= gid_d;
            hold_q      <= hold_d;
            timeout     <= timeout_d;
            armed_q     <= 1'b1;
        end
    end

endmodule
